instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/instr_fetch_if.sv | 32 +++
 rtl/fetch_buf.sv | 63 ++++++
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: datapath width, the NOP encoding presented when
// no instruction is available, the default reset fetch address, the fetch
// FSM state type and a word-alignment helper.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  // FETCH: request may be issued; STALL: buffer full, no request;
  // DROP : one idle cycle after a redirect so a withdrawn request is not
  //        confused with the request to the new target.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bundles the instruction-memory bus, the decode handshake and the redirect
// inputs of the fetch unit.
//   master : fetch unit side (drives imem_req/imem_addr and the decode outputs)
//   slave  : environment side (memory, decode and execute stages)
// ---------------------------------------------------------------------------
interface instr_fetch_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_buf.sv
// ---------------------------------------------------------------------------
// fetch_buf
// Small FIFO holding {pc, instr} pairs between memory response and decode.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (pointers/count only)
//   i_push       write i_data at the tail
//   i_pop        retire the head entry
//   i_flush      empty the buffer; overrides push and pop
//   i_data       entry to write
//   o_data       head entry (straight from the storage registers)
//   o_count      current occupancy
// Push and pop together are legal at any occupancy, including full.
// ---------------------------------------------------------------------------
module fetch_buf
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Storage carries no reset; the count qualifies it.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit: issues one word fetch at a time to instruction
// memory, buffers returned words with their PCs, and hands them to decode.
// A redirect from execute flushes the buffer and restarts fetch at the
// (word-aligned) target after one idle request cycle.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   bus.master   imem_req/imem_addr/imem_ack/imem_rdata memory bus,
//                instr_valid/instr/instr_pc/instr_ready decode handshake,
//                redirect/redirect_pc from execute
// Parameters:
//   RESET_PC     first fetch address after reset
//   BUF_DEPTH    buffer entries, 2 or 4
// ---------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  instr_fetch_if.master   bus
);

  localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  fetch_state_e      r_state;
  fetch_state_e      w_state_n;
  logic              r_req;
  logic              w_req_n;
  logic [XLEN-1:0]   r_pc;

  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_valid;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_n;
  logic [2*XLEN-1:0] w_head;

  // Occupancy after this edge decides whether a request may be held next
  // cycle, so a same-cycle pop frees space for it.
  always_comb begin
    w_flush   = bus.redirect;
    w_valid   = (w_count != '0);
    w_push    = r_req && bus.imem_ack && !bus.redirect;
    w_pop     = w_valid && bus.instr_ready && !bus.redirect;
    w_count_n = w_flush ? '0 : (w_count + CNT_W'(w_push) - CNT_W'(w_pop));
    w_state_n = r_state;
    if (bus.redirect) begin
      w_state_n = DROP;
    end else begin
      case (r_state)
        FETCH:   if (w_count_n >= DEPTH_C) w_state_n = STALL;
        STALL:   if (w_count_n <  DEPTH_C) w_state_n = FETCH;
        DROP:    w_state_n = (w_count_n < DEPTH_C) ? FETCH : STALL;
        default: w_state_n = FETCH;
      endcase
    end
    w_req_n = (w_state_n == FETCH);
  end

  // Request/PC register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
      r_req   <= 1'b0;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_n;
      r_req   <= w_req_n;
      if (bus.redirect)  r_pc <= word_align(bus.redirect_pc);
      else if (w_push)   r_pc <= r_pc + 32'd4;
    end
  end

  fetch_buf #(
    .DATA_W (2*XLEN),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  ({r_pc, bus.imem_rdata}),
    .o_data  (w_head),
    .o_count (w_count)
  );

  // Decode outputs come only from buffer registers; an empty buffer shows NOP.
  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_valid ? w_head[XLEN-1:0]        : NOP_INSTR;
  assign bus.instr_pc    = w_valid ? w_head[2*XLEN-1:XLEN]   : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. A queue holds {pc, word} for every
// accepted fetch; each decode pop is compared against its head. A second
// instance with RESET_PC = FFFF_FFF8 and a 4-entry buffer covers PC wrap.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_tot;
  logic [63:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus();
  instr_fetch_if bus2();

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_fetch #(
    .RESET_PC  (32'hFFFF_FFF8),
    .BUF_DEPTH (4)
  ) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: drive memory data and run the scoreboard at the falling edge,
  // then return 1 time unit after the rising edge.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    bus.imem_rdata  = mem_word(bus.imem_addr);
    bus2.imem_rdata = mem_word(bus2.imem_addr);
    if (bus.redirect) begin
      exp_q.delete();
    end else begin
      if (bus.instr_valid && bus.instr_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_pc", bus.instr_pc, e[63:32]);
          chk("sb_instr", bus.instr, e[31:0]);
        end
      end
      if (bus.imem_req && bus.imem_ack)
        exp_q.push_back({bus.imem_addr, bus.imem_rdata});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst = 1'b1;
    bus.imem_ack = 1'b0;  bus.imem_rdata = '0;  bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;  bus.redirect_pc = '0;
    bus2.imem_ack = 1'b0; bus2.imem_rdata = '0; bus2.instr_ready = 1'b0;
    bus2.redirect = 1'b0; bus2.redirect_pc = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'h0000_0000);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'h0000_0013);
    chk("rst_pc",    bus.instr_pc, 32'h0000_0000);
    chk("rst_addr2", bus2.imem_addr, 32'hFFFF_FFF8);

    // Reset release with memory and decode always ready
    bus.imem_ack  = 1'b1; bus.instr_ready  = 1'b1;
    bus2.imem_ack = 1'b1; bus2.instr_ready = 1'b1;
    rst = 1'b0;
    tick();
    chk("first_req",    32'(bus.imem_req), 32'd1);
    chk("first_addr",   bus.imem_addr, 32'h0000_0000);
    chk("first_valid0", 32'(bus.instr_valid), 32'd0);
    chk("wrap_req",     32'(bus2.imem_req), 32'd1);
    chk("wrap_addr",    bus2.imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("first_valid1", 32'(bus.instr_valid), 32'd1);
    chk("first_pc",     bus.instr_pc, 32'h0000_0000);
    chk("wrap_pc0",     bus2.instr_pc, 32'hFFFF_FFF8);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("seq_valid", 32'(bus.instr_valid), 32'd1);
      chk("seq_pc",    bus.instr_pc, 32'(i * 4));
      chk("wrap_pc",   bus2.instr_pc, 32'hFFFF_FFF8 + 32'(i * 4));
    end

    // Decode stalls: buffer fills to depth and requests stop
    bus.instr_ready = 1'b0;
    repeat (3) tick();
    chk("stall_req",   32'(bus.imem_req), 32'd0);
    chk("stall_addr",  bus.imem_addr, 32'h0000_0014);
    chk("stall_head",  bus.instr_pc, 32'h0000_000C);
    chk("stall_count", 32'(exp_q.size()), 32'd2);
    bus.instr_ready = 1'b1;
    repeat (4) tick();
    chk("drain_req", 32'(bus.imem_req), 32'd1);

    // Redirect with a same-cycle ack
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0102;
    tick();
    chk("redir_valid", 32'(bus.instr_valid), 32'd0);
    chk("redir_req",   32'(bus.imem_req), 32'd0);
    chk("redir_addr",  bus.imem_addr, 32'h0000_0100);
    bus.redirect = 1'b0;
    tick();
    chk("redir_req1",  32'(bus.imem_req), 32'd1);
    chk("redir_addr1", bus.imem_addr, 32'h0000_0100);
    tick();
    chk("redir_valid1", 32'(bus.instr_valid), 32'd1);
    chk("redir_pc1",    bus.instr_pc, 32'h0000_0100);

    // Memory holds off: request and address hold, then redirect withdraws it
    bus.imem_ack = 1'b0;
    repeat (3) begin
      tick();
      chk("hold_req",  32'(bus.imem_req), 32'd1);
      chk("hold_addr", bus.imem_addr, 32'h0000_0104);
    end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
    tick();
    chk("wd_req0",  32'(bus.imem_req), 32'd0);
    chk("wd_addr0", bus.imem_addr, 32'h0000_0200);
    bus.redirect = 1'b0;
    tick();
    chk("wd_req1",  32'(bus.imem_req), 32'd1);
    chk("wd_addr1", bus.imem_addr, 32'h0000_0200);

    // Back-to-back redirects: the last target wins
    bus.imem_ack = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0300;
    tick();
    bus.redirect_pc = 32'h0000_0407;
    tick();
    chk("b2b_req0",  32'(bus.imem_req), 32'd0);
    chk("b2b_addr0", bus.imem_addr, 32'h0000_0404);
    bus.redirect = 1'b0;
    tick();
    chk("b2b_req1",  32'(bus.imem_req), 32'd1);
    chk("b2b_addr1", bus.imem_addr, 32'h0000_0404);
    tick();
    chk("b2b_pc", bus.instr_pc, 32'h0000_0404);

    // Asynchronous reset pulse while stalled
    bus.instr_ready = 1'b0;
    repeat (4) tick();
    chk("pre_rst_req", 32'(bus.imem_req), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req",   32'(bus.imem_req), 32'd0);
    chk("arst_addr",  bus.imem_addr, 32'h0000_0000);
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_instr", bus.instr, 32'h0000_0013);
    chk("arst_pc",    bus.instr_pc, 32'h0000_0000);
    exp_q.delete();
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    chk("restart_req",  32'(bus.imem_req), 32'd1);
    chk("restart_addr", bus.imem_addr, 32'h0000_0000);
    tick();
    chk("restart_valid", 32'(bus.instr_valid), 32'd1);
    chk("restart_pc",    bus.instr_pc, 32'h0000_0000);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
